// File: rtl/sram2rw_bus_ctrl.sv
// Bus-to-SRAM controller: one outstanding transaction, registered SRAM strobes.
// Define SRAM2RW_BUS_CTRL_RMW_EN to service partial writes by read-modify-write.
module sram2rw_bus_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic [31:0]       addr_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              sram_csb_o,
  output logic              sram_web_o,
  output logic              sram_oeb_o,
  output logic [ADDR_W-1:0] sram_a_o,
  output logic [31:0]       sram_i_o,
  input  logic [31:0]       sram_o_i
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("sram2rw_bus_ctrl: DATA_W must be 32");
  end

`ifdef SRAM2RW_BUS_CTRL_RMW_EN
  typedef enum logic [1:0] {IDLE, ACC, RMW_WR, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;
`endif

  state_t      state;
  logic        rd_q;
  logic        err_q;
  logic [31:0] sram_i_q;
  logic        oor;
  logic        unused_addr;

  assign unused_addr = ^addr_i[1:0];
  assign oor         = (addr_i >> (ADDR_W + 2)) != 32'd0;
  assign gnt_o       = req_i & ~rst_i & (state == IDLE);
  // Read data is passed straight from the SRAM during the response cycle.
  assign rdata_o     = (rvalid_o & rd_q) ? sram_o_i : 32'd0;

`ifdef SRAM2RW_BUS_CTRL_RMW_EN
  logic        rmw_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] merged;

  always_comb begin
    merged = sram_o_i;
    for (int k = 0; k < 4; k++)
      if (be_q[k]) merged[8*k +: 8] = wdata_q[8*k +: 8];
  end
  // Merge data only exists in RMW_WR, the cycle the old word appears on sram_o_i.
  assign sram_i_o = (state == RMW_WR) ? merged : sram_i_q;
`else
  assign sram_i_o = sram_i_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      rvalid_o   <= 1'b0;
      err_o      <= 1'b0;
      rd_q       <= 1'b0;
      err_q      <= 1'b0;
      sram_csb_o <= 1'b1;
      sram_web_o <= 1'b1;
      sram_oeb_o <= 1'b1;
      sram_a_o   <= '0;
      sram_i_q   <= 32'd0;
`ifdef SRAM2RW_BUS_CTRL_RMW_EN
      rmw_q      <= 1'b0;
      wdata_q    <= 32'd0;
      be_q       <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: if (gnt_o) begin
          state    <= ACC;
          rd_q     <= 1'b0;
          err_q    <= 1'b0;
          sram_a_o <= addr_i[ADDR_W+1:2];
          if (oor) err_q <= 1'b1;
          else if (!we_i) begin
            sram_csb_o <= 1'b0;
            rd_q       <= 1'b1;
          end else if (be_i == 4'hF) begin
            sram_csb_o <= 1'b0;
            sram_web_o <= 1'b0;
            sram_i_q   <= wdata_i;
          end else if (be_i != 4'h0) begin
`ifdef SRAM2RW_BUS_CTRL_RMW_EN
            sram_csb_o <= 1'b0;
            rmw_q      <= 1'b1;
            wdata_q    <= wdata_i;
            be_q       <= be_i;
`else
            err_q      <= 1'b1;
`endif
          end
        end
        ACC: begin
          sram_csb_o <= 1'b1;
          sram_web_o <= 1'b1;
          sram_oeb_o <= sram_csb_o | ~sram_web_o;
`ifdef SRAM2RW_BUS_CTRL_RMW_EN
          if (rmw_q) begin
            state      <= RMW_WR;
            sram_csb_o <= 1'b0;
            sram_web_o <= 1'b0;
          end else begin
            state    <= RESP;
            rvalid_o <= 1'b1;
            err_o    <= err_q;
          end
`else
          state    <= RESP;
          rvalid_o <= 1'b1;
          err_o    <= err_q;
`endif
        end
`ifdef SRAM2RW_BUS_CTRL_RMW_EN
        RMW_WR: begin
          state      <= RESP;
          sram_csb_o <= 1'b1;
          sram_web_o <= 1'b1;
          sram_oeb_o <= 1'b1;
          rvalid_o   <= 1'b1;
          err_o      <= 1'b0;
        end
`endif
        RESP: begin
          state      <= IDLE;
          rvalid_o   <= 1'b0;
          err_o      <= 1'b0;
          sram_oeb_o <= 1'b1;
          rd_q       <= 1'b0;
`ifdef SRAM2RW_BUS_CTRL_RMW_EN
          rmw_q      <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram2rw_bus_ctrl.sv
// Directed bench for sram2rw_bus_ctrl with a behavioural synchronous SRAM.
module tb_sram2rw_bus_ctrl;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst, req, gnt, we, rvalid, err, csb, web, oeb;
  logic [31:0]       addr, wdata, rdata, s_i, s_o;
  logic [3:0]        be;
  logic [ADDR_W-1:0] s_a;
  logic [31:0]       mem [0:(1<<ADDR_W)-1];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sram2rw_bus_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .sram_csb_o(csb), .sram_web_o(web), .sram_oeb_o(oeb), .sram_a_o(s_a),
    .sram_i_o(s_i), .sram_o_i(s_o)
  );

  // Synchronous SRAM: CE on clk, read data appears after the sampling edge.
  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 32'd0;
    s_o = 32'd0;
  end
  always @(posedge clk)
    if (!csb) begin
      if (!web) mem[s_a] <= s_i;
      else      s_o <= mem[s_a];
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the response cycle.
  task automatic xact(input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, input int lat, output logic e,
                      output logic [31:0] r, output logic c1, output logic o);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    #1 chk("gnt_n", gnt, 1);
    @(negedge clk);
    req = 1'b0; we = ~w; addr = 32'hFFFF_FFFC; be = ~b; wdata = ~d;
    chk("gnt_n1", gnt, 0);
    chk("rvalid_n1", rvalid, 0);
    c1 = csb;
    for (int i = 2; i < lat; i++) begin
      @(negedge clk);
      chk("rvalid_early", rvalid, 0);
    end
    @(negedge clk);
    chk("rvalid_resp", rvalid, 1);
    e = err; r = rdata; o = oeb;
    @(negedge clk);
    chk("rvalid_after", rvalid, 0);
  endtask

  logic        e, c1, o;
  logic [31:0] r;
  int          plat;

  initial begin
`ifdef SRAM2RW_BUS_CTRL_RMW_EN
    plat = 3;
`else
    plat = 2;
`endif
    rst = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h10; be = 4'hF; wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_strobes", {csb, web, oeb}, 3'b111);
    chk("rst_a", s_a, 0);
    chk("rst_i", s_i, 0);
    rst = 1'b0; req = 1'b0;

    // Full write then read back
    xact(1, 32'h10, 4'hF, 32'hDEADBEEF, 2, e, r, c1, o);
    chk("wr_err", e, 0); chk("wr_rdata", r, 0); chk("wr_csb", c1, 0); chk("wr_oeb", o, 1);
    xact(0, 32'h10, 4'h0, 32'h0, 2, e, r, c1, o);
    chk("rd_err", e, 0); chk("rd_data", r, 32'hDEADBEEF); chk("rd_csb", c1, 0); chk("rd_oeb", o, 0);

    // Partial write
    xact(1, 32'h08, 4'hF, 32'h11223344, 2, e, r, c1, o);
    xact(1, 32'h08, 4'b0101, 32'hAABBCCDD, plat, e, r, c1, o);
    chk("pw_rdata", r, 0);
`ifdef SRAM2RW_BUS_CTRL_RMW_EN
    chk("pw_err", e, 0); chk("pw_csb", c1, 0);
    xact(0, 32'h08, 4'h0, 32'h0, 2, e, r, c1, o);
    chk("pw_read", r, 32'h11BB33DD);
`else
    chk("pw_err", e, 1); chk("pw_csb", c1, 1);
    xact(0, 32'h08, 4'h0, 32'h0, 2, e, r, c1, o);
    chk("pw_read", r, 32'h11223344);
`endif

    // be=0 write is a no-op
    xact(1, 32'h10, 4'h0, 32'hFFFFFFFF, 2, e, r, c1, o);
    chk("nop_err", e, 0); chk("nop_csb", c1, 1);
    xact(0, 32'h10, 4'h0, 32'h0, 2, e, r, c1, o);
    chk("nop_read", r, 32'hDEADBEEF);

    // Out of range
    xact(0, 32'h80, 4'h0, 32'h0, 2, e, r, c1, o);
    chk("oor_err", e, 1); chk("oor_rdata", r, 0); chk("oor_csb", c1, 1);

    // Top word of the array
    xact(1, 32'h7C, 4'hF, 32'h5A5A0001, 2, e, r, c1, o);
    xact(0, 32'h7C, 4'h0, 32'h0, 2, e, r, c1, o);
    chk("top_read", r, 32'h5A5A0001); chk("top_err", e, 0);

    // Back-to-back requests: one grant every third cycle
    req = 1'b1; we = 1'b0; addr = 32'h10; be = 4'h0;
    for (int i = 0; i < 9; i++) begin
      #1 chk("b2b_gnt", gnt, (i % 3 == 0) ? 32'd1 : 32'd0);
      if (i % 3 == 2) chk("b2b_rdata", rdata, 32'hDEADBEEF);
      @(negedge clk);
    end
    req = 1'b0;
    @(negedge clk);

    // Reset during ACC of a read aborts it
    req = 1'b1; we = 1'b0; addr = 32'h10;
    #1 chk("abort_gnt", gnt, 1);
    @(negedge clk);
    req = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("abort_rvalid", rvalid, 0);
    chk("abort_strobes", {csb, oeb}, 2'b11);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rvalid2", rvalid, 0);
    xact(0, 32'h10, 4'h0, 32'h0, 2, e, r, c1, o);
    chk("post_abort_read", r, 32'hDEADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sram2rw_bus_ctrl.md
SRAM2RW_BUS_CTRL -- requirements
Module: sram2rw_bus_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high: clk_i is the only clock, rst_i is the reset, sampled on clk_i rising edge.
REQ-002 Parameter ADDR_W, default 5, SRAM word-address width (2^ADDR_W words).
REQ-003 Parameter DATA_W, fixed 32, word width; any other value SHALL be a elaboration error.
REQ-004 clk_i  in  1  rising-edge clock; the SRAM port CE is tied to clk_i at top level.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 req_i  in  1  bus request; addr_i/we_i/be_i/wdata_i valid while high.
REQ-007 gnt_o  out  1  request accepted this cycle.
REQ-008 addr_i  in  32  byte address; word index = addr_i[ADDR_W+1:2].
REQ-009 we_i  in  1  1 = write, 0 = read.
REQ-010 be_i  in  4  byte enables, bit k = wdata_i[8k+7:8k].
REQ-011 wdata_i  in  32  write data.
REQ-012 rvalid_o  out  1  single-cycle response strobe.
REQ-013 rdata_o  out  32  read data, valid with rvalid_o; 0 otherwise.
REQ-014 err_o  out  1  error flag, valid with rvalid_o.
REQ-015 sram_csb_o, sram_web_o, sram_oeb_o  out  1 each  active-low SRAM strobes, registered.
REQ-016 sram_a_o  out  ADDR_W  registered SRAM address.
REQ-017 sram_i_o  out  32  registered SRAM write data.
REQ-018 sram_o_i  in  32  SRAM read data.

Function
REQ-019 FSM states SHALL be IDLE, ACC, RMW_WR, RESP; one transaction outstanding at most.
REQ-020 gnt_o SHALL equal req_i AND state==IDLE (combinational); accepted cycle = N.
REQ-021 Range: addr_i[31:ADDR_W+2] nonzero SHALL give no SRAM access, rvalid_o=1, err_o=1 in N+2.
REQ-022 Read: at end of N register csb=0, web=1, address; state ACC in N+1 (SRAM samples at end of N+1); RESP in N+2 with oeb=0, rvalid_o=1, rdata_o=sram_o_i, err_o=0.
REQ-023 Full write (be_i=4'hF): ACC in N+1 with csb=0, web=0, sram_i_o=wdata_i; rvalid_o=1, err_o=0 in N+2.
REQ-024 Write with be_i=0 SHALL be a no-op: csb stays 1, rvalid_o=1, err_o=0 in N+2.
REQ-025 Partial write: see REQ-033/034.
REQ-026 sram_csb_o SHALL be 0 only in ACC and RMW_WR; sram_web_o 0 only for write strobes; sram_oeb_o 0 only in cycles following a read strobe.
REQ-027 RESP SHALL last one cycle and return to IDLE; req_i in RESP SHALL NOT be granted (throughput one transaction per 3 cycles, 4 for RMW).
REQ-028 Request fields SHALL be latched at grant; changes after gnt_o have no effect.
REQ-029 rdata_o SHALL be 0 for write responses and error responses.

Reset
REQ-030 rst_i high SHALL force, at the next edge: state IDLE, gnt_o=0, rvalid_o=0, err_o=0, rdata_o=0, csb/web/oeb=1, sram_a_o=0, sram_i_o=0.
REQ-031 Reset mid-transaction SHALL abort it: no response, no further SRAM strobe; an already-sampled SRAM write is not undone.
REQ-032 First grant possible in the cycle after rst_i deasserts.

Configuration
REQ-033 Macro SRAM2RW_BUS_CTRL_RMW_EN defined: partial write SHALL read in N+1 (ACC), in N+2 (RMW_WR) drive csb=0, web=0, sram_i_o = merge(sram_o_i, wdata_i, be_i); rvalid_o=1, err_o=0 in N+3.
REQ-034 Macro undefined: partial write SHALL perform no SRAM access; rvalid_o=1, err_o=1 in N+2; RMW_WR state absent.

Verification
REQ-035 Write 0xDEADBEEF to 0x10, be=F; read 0x10 -> gnt in N, rvalid in N+2 both, rdata_o=0xDEADBEEF, err_o=0.
REQ-036 RMW_EN: word 0x11223344 at 0x08, write 0xAABBCCDD be=4'b0101 -> rvalid N+3, later read returns 0x11BB33DD.
REQ-037 RMW_EN undefined: same partial write -> rvalid N+2 err_o=1, read returns 0x11223344.
REQ-038 Read addr 0x0000_0080 (ADDR_W=5) -> no csb low, rvalid N+2 err_o=1 rdata_o=0.
REQ-039 req_i held high continuously -> gnt_o pulses every 3rd cycle, never in ACC/RESP.
REQ-040 rst_i asserted in ACC of a read -> no rvalid_o, csb/oeb=1 next cycle, gnt_o on next req after release.
